// File: rtl/flash_seq_pkg.sv
// Shared encodings for the SPI NOR flash command sequencer:
// command ops, flash opcodes, status bits and the sequencer state set.
package flash_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_PROGRAM = 2'b01,
    OP_ERASE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } cmd_op_e;

  localparam logic [7:0] FLASH_WREN = 8'h06;
  localparam logic [7:0] FLASH_READ = 8'h03;
  localparam logic [7:0] FLASH_PP   = 8'h02;
  localparam logic [7:0] FLASH_SE   = 8'h20;
  localparam logic [7:0] FLASH_RDSR = 8'h05;

  localparam int WIP_BIT    = 0;
  localparam int POLL_CNT_W = 11;
  localparam int DATA_BYTES = 4;

  localparam logic [2:0] LAST_ADDR_IDX = 3'd2;
  localparam logic [2:0] LAST_DATA_IDX = 3'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WREN,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_POLL_CMD,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_RESP
  } seq_state_e;

  function automatic logic [7:0] cmd_opcode(input cmd_op_e op);
    case (op)
      OP_READ:    cmd_opcode = FLASH_READ;
      OP_PROGRAM: cmd_opcode = FLASH_PP;
      default:    cmd_opcode = FLASH_SE;
    endcase
  endfunction

endpackage

// File: rtl/flash_poll_timer.sv
// Status-poll bookkeeping: counts RDSR reads against the poll limit and
// times the idle gap between consecutive RDSR frames.
module flash_poll_timer
  import flash_seq_pkg::*;
#(
  parameter int MAX_POLLS = 1024,
  parameter int POLL_GAP  = 16
) (
  input  logic p_clk,
  input  logic p_reset,
  input  logic clr,
  input  logic poll_inc,
  input  logic gap_run,
  output logic poll_limit,
  output logic gap_done
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  logic [POLL_CNT_W-1:0] poll_cnt_reg, poll_cnt_next;
  logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;

  // poll_limit flags that the read now in flight is the last one allowed
  assign poll_limit = (poll_cnt_reg == POLL_CNT_W'(MAX_POLLS - 1));
  assign gap_done   = gap_run && (gap_cnt_reg == GAP_W'(POLL_GAP - 1));

  always_comb begin
    poll_cnt_next = poll_cnt_reg;
    if (clr) begin
      poll_cnt_next = '0;
    end else if (poll_inc) begin
      poll_cnt_next = poll_cnt_reg + 1'b1;
    end

    gap_cnt_next = '0;
    if (gap_run && !gap_done) begin
      gap_cnt_next = gap_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      poll_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      poll_cnt_reg <= poll_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Expands one word-level flash command into the SPI byte stream, with WREN
// ahead of program/erase and RDSR polling until WIP clears or times out.
module flash_cmd_sequencer
  import flash_seq_pkg::*;
#(
  parameter int MAX_POLLS = 1024,
  parameter int POLL_GAP  = 16
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        spi_tx_valid,
  input  logic        spi_tx_ready,
  output logic [7:0]  spi_tx_byte,
  output logic        spi_cs_hold,
  input  logic        spi_rx_valid,
  input  logic [7:0]  spi_rx_byte
);

  seq_state_e  state_reg, state_next;
  cmd_op_e     op_reg, op_next;
  logic [23:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;
  logic [2:0]  idx_reg, idx_next;
  logic        pend_reg, pend_next;

  logic        byte_state;
  logic        byte_done;
  logic        accept;
  logic [7:0]  tx_byte_sel;
  logic        hold_sel;
  logic        poll_inc;
  logic        gap_run;
  logic        poll_limit;
  logic        gap_done;

  logic [7:0]  wdata_byte [DATA_BYTES];

  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_wdata_byte
    assign wdata_byte[gi] = wdata_reg[8*(DATA_BYTES-1-gi) +: 8];
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_err   = rsp_valid & err_reg;
  assign rsp_rdata = rdata_reg;
  assign poll_inc  = byte_done && (state_reg == ST_POLL_RD);
  assign gap_run   = (state_reg == ST_POLL_WAIT);

  flash_poll_timer #(
    .MAX_POLLS (MAX_POLLS),
    .POLL_GAP  (POLL_GAP)
  ) u_poll_timer (
    .p_clk      (p_clk),
    .p_reset    (p_reset),
    .clr        (accept),
    .poll_inc   (poll_inc),
    .gap_run    (gap_run),
    .poll_limit (poll_limit),
    .gap_done   (gap_done)
  );

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    idx_next    = idx_reg;
    pend_next   = pend_reg;
    byte_state  = 1'b0;
    tx_byte_sel = 8'h00;
    hold_sel    = 1'b0;
    accept      = 1'b0;

    case (state_reg)
      ST_WREN: begin
        byte_state  = 1'b1;
        tx_byte_sel = FLASH_WREN;
      end
      ST_CMD: begin
        byte_state  = 1'b1;
        tx_byte_sel = cmd_opcode(op_reg);
        hold_sel    = 1'b1;
      end
      ST_ADDR: begin
        byte_state = 1'b1;
        hold_sel   = !((op_reg == OP_ERASE) && (idx_reg == LAST_ADDR_IDX));
        case (idx_reg)
          3'd0:    tx_byte_sel = addr_reg[23:16];
          3'd1:    tx_byte_sel = addr_reg[15:8];
          default: tx_byte_sel = addr_reg[7:0];
        endcase
      end
      ST_DATA: begin
        byte_state  = 1'b1;
        tx_byte_sel = (op_reg == OP_READ) ? 8'h00 : wdata_byte[idx_reg[1:0]];
        hold_sel    = (idx_reg != LAST_DATA_IDX);
      end
      ST_POLL_CMD: begin
        byte_state  = 1'b1;
        tx_byte_sel = FLASH_RDSR;
        hold_sel    = 1'b1;
      end
      ST_POLL_RD: begin
        byte_state = 1'b1;
      end
      default: ;
    endcase

    // A byte is presented only while none is outstanding at the engine
    spi_tx_valid = byte_state & ~pend_reg;
    spi_tx_byte  = spi_tx_valid ? tx_byte_sel : 8'h00;
    spi_cs_hold  = spi_tx_valid & hold_sel;
    byte_done    = byte_state & pend_reg & spi_rx_valid;

    if (spi_tx_valid && spi_tx_ready) begin
      pend_next = 1'b1;
    end else if (byte_done) begin
      pend_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          op_next    = cmd_op_e'(cmd_op);
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          rdata_next = 32'h0;
          err_next   = (cmd_op_e'(cmd_op) == OP_ILLEGAL);
          idx_next   = 3'd0;
          pend_next  = 1'b0;
          case (cmd_op_e'(cmd_op))
            OP_READ:    state_next = ST_CMD;
            OP_ILLEGAL: state_next = ST_RESP;
            default:    state_next = ST_WREN;
          endcase
        end
      end
      ST_WREN: begin
        if (byte_done) state_next = ST_CMD;
      end
      ST_CMD: begin
        if (byte_done) begin
          state_next = ST_ADDR;
          idx_next   = 3'd0;
        end
      end
      ST_ADDR: begin
        if (byte_done) begin
          if (idx_reg == LAST_ADDR_IDX) begin
            idx_next   = 3'd0;
            state_next = (op_reg == OP_ERASE) ? ST_POLL_CMD : ST_DATA;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          if (op_reg == OP_READ) begin
            rdata_next = {rdata_reg[23:0], spi_rx_byte};
          end
          if (idx_reg == LAST_DATA_IDX) begin
            idx_next   = 3'd0;
            state_next = (op_reg == OP_READ) ? ST_RESP : ST_POLL_CMD;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      ST_POLL_CMD: begin
        if (byte_done) state_next = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        if (byte_done) begin
          if (!spi_rx_byte[WIP_BIT]) begin
            err_next   = 1'b0;
            state_next = ST_RESP;
          end else if (poll_limit) begin
            err_next   = 1'b1;
            state_next = ST_RESP;
          end else begin
            state_next = ST_POLL_WAIT;
          end
        end
      end
      ST_POLL_WAIT: begin
        if (gap_done) state_next = ST_POLL_CMD;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_READ;
      addr_reg  <= 24'h0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
      idx_reg   <= 3'd0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      idx_reg   <= idx_next;
      pend_reg  <= pend_next;
    end
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Scoreboard bench: an SPI engine model checks each MOSI byte against a queue
// of expected bytes and feeds MISO replies; responses are checked from a queue.
module tb_flash_cmd_sequencer;

  localparam int MAX_POLLS = 4;
  localparam int POLL_GAP  = 3;

  logic        p_clk = 1'b0;
  logic        p_reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [23:0] cmd_addr = 24'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        spi_tx_valid;
  logic        spi_tx_ready = 1'b0;
  logic [7:0]  spi_tx_byte;
  logic        spi_cs_hold;
  logic        spi_rx_valid = 1'b0;
  logic [7:0]  spi_rx_byte = 8'h00;

  flash_cmd_sequencer #(
    .MAX_POLLS (MAX_POLLS),
    .POLL_GAP  (POLL_GAP)
  ) dut (
    .p_clk        (p_clk),
    .p_reset      (p_reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .spi_tx_valid (spi_tx_valid),
    .spi_tx_ready (spi_tx_ready),
    .spi_tx_byte  (spi_tx_byte),
    .spi_cs_hold  (spi_cs_hold),
    .spi_rx_valid (spi_rx_valid),
    .spi_rx_byte  (spi_rx_byte)
  );

  always #5 p_clk = ~p_clk;

  int cyc = 0;
  always @(posedge p_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       hold;
    logic       gap;
  } tx_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  tx_exp_t    exp_q[$];
  logic [7:0] miso_q[$];
  rsp_exp_t   rsp_q[$];

  int checks = 0;
  int errors = 0;

  logic       outstanding = 1'b0;
  logic       seen = 1'b0;
  logic       spurious_req = 1'b0;
  int         stall_cnt = 0;
  int         stall_at = -1;
  int         rx_delay = 0;
  int         tx_count = 0;
  int         last_rx_cyc = 0;
  logic [7:0] lat_b = 8'h00;
  logic       lat_h = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_tx(input logic [7:0] b, input logic hold, input logic [7:0] miso,
                         input logic gap);
    tx_exp_t e;
    e.b = b;
    e.hold = hold;
    e.gap = gap;
    exp_q.push_back(e);
    miso_q.push_back(miso);
  endtask

  task automatic push_poll(input logic [7:0] status, input logic gap);
    push_tx(8'h05, 1'b1, 8'h00, gap);
    push_tx(8'h00, 1'b0, status, 1'b0);
  endtask

  task automatic push_rsp(input logic [31:0] rdata, input logic err);
    rsp_exp_t r;
    r.rdata = rdata;
    r.err = err;
    rsp_q.push_back(r);
  endtask

  task automatic push_hdr(input logic [7:0] opc, input logic [23:0] a, input logic last_rel);
    push_tx(opc, 1'b1, 8'h00, 1'b0);
    push_tx(a[23:16], 1'b1, 8'h00, 1'b0);
    push_tx(a[15:8], 1'b1, 8'h00, 1'b0);
    push_tx(a[7:0], !last_rel, 8'h00, 1'b0);
  endtask

  task automatic push_read_data(input logic [31:0] d);
    push_tx(8'h00, 1'b1, d[31:24], 1'b0);
    push_tx(8'h00, 1'b1, d[23:16], 1'b0);
    push_tx(8'h00, 1'b1, d[15:8], 1'b0);
    push_tx(8'h00, 1'b0, d[7:0], 1'b0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge p_clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge p_clk);
      n++;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    tx_count = 0;
    @(negedge p_clk);
    cmd_valid = 1'b0;
    $display("CMD op=%0d addr=0x%06h wdata=0x%08h", op, a, d);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((rsp_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      @(negedge p_clk);
      n++;
    end
    chk("rsp_timeout", 32'(rsp_q.size()), 0);
    chk("tx_left", 32'(exp_q.size()), 0);
    @(negedge p_clk);
    chk("miso_left", 32'(miso_q.size()), 0);
  endtask

  // SPI engine model
  initial begin : engine
    tx_exp_t e;
    forever begin
      @(negedge p_clk);
      spi_rx_valid = 1'b0;
      if (p_reset) begin
        outstanding = 1'b0;
        seen = 1'b0;
        stall_cnt = 0;
        rx_delay = 0;
        spi_tx_ready = 1'b0;
      end else if (spurious_req) begin
        spurious_req = 1'b0;
        spi_rx_valid = 1'b1;
        spi_rx_byte = 8'h5A;
      end else if (spi_tx_ready) begin
        spi_tx_ready = 1'b0;
        outstanding = 1'b1;
        rx_delay = 1;
      end else if (outstanding) begin
        chk("one_outstanding", 32'(spi_tx_valid), 0);
        if (rx_delay > 0) begin
          rx_delay--;
        end else begin
          spi_rx_valid = 1'b1;
          spi_rx_byte = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
          outstanding = 1'b0;
          last_rx_cyc = cyc;
        end
      end else if (spi_tx_valid) begin
        if (!seen) begin
          seen = 1'b1;
          lat_b = spi_tx_byte;
          lat_h = spi_cs_hold;
          if (exp_q.size() == 0) begin
            chk("unexpected_tx", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", 32'(spi_tx_byte), 32'(e.b));
            chk("cs_hold", 32'(spi_cs_hold), 32'(e.hold));
            if (e.gap) chk("poll_gap", 32'(cyc - last_rx_cyc), POLL_GAP + 1);
          end
          if (tx_count == stall_at) stall_cnt = 5;
          tx_count++;
        end else begin
          chk("stall_byte", 32'(spi_tx_byte), 32'(lat_b));
          chk("stall_hold", 32'(spi_cs_hold), 32'(lat_h));
        end
        if (stall_cnt > 0) begin
          stall_cnt--;
        end else begin
          spi_tx_ready = 1'b1;
          seen = 1'b0;
        end
      end
    end
  end

  // Response monitor
  initial begin : monitor
    rsp_exp_t r;
    forever begin
      @(negedge p_clk);
      if (!p_reset && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_q.size()), 1);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(r.err));
          chk("ready_in_resp", 32'(cmd_ready), 0);
          $display("RSP rdata=0x%08h err=%0d", rsp_rdata, rsp_err);
        end
        @(negedge p_clk);
        chk("rsp_pulse", 32'(rsp_valid), 0);
        chk("ready_after_rsp", 32'(cmd_ready), 1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(negedge p_clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_tx_valid", 32'(spi_tx_valid), 0);
    chk("rst_tx_byte", 32'(spi_tx_byte), 0);
    chk("rst_cs_hold", 32'(spi_cs_hold), 0);
    p_reset = 1'b0;

    // Stray rx pulse while idle must be ignored
    spurious_req = 1'b1;
    repeat (3) @(negedge p_clk);
    chk("spurious_busy", 32'(busy), 0);
    chk("spurious_rdata", rsp_rdata, 0);

    // PROGRAM, WIP=1 twice then clear; a command pushed while busy is dropped
    push_tx(8'h06, 1'b0, 8'h00, 1'b0);
    push_hdr(8'h02, 24'h000000, 1'b0);
    push_tx(8'hFF, 1'b1, 8'h00, 1'b0);
    push_tx(8'h00, 1'b1, 8'h00, 1'b0);
    push_tx(8'hFF, 1'b1, 8'h00, 1'b0);
    push_tx(8'h00, 1'b0, 8'h00, 1'b0);
    push_poll(8'h01, 1'b0);
    push_poll(8'h01, 1'b1);
    push_poll(8'h00, 1'b1);
    push_rsp(32'h0, 1'b0);
    issue(2'b01, 24'h000000, 32'hFF00FF00);
    repeat (3) begin
      cmd_valid = 1'b1;
      cmd_op = 2'b00;
      chk("busy_ready", 32'(cmd_ready), 0);
      chk("busy_flag", 32'(busy), 1);
      @(negedge p_clk);
    end
    cmd_valid = 1'b0;
    wait_done(2000);

    // READ back, no WREN
    push_hdr(8'h03, 24'h000000, 1'b0);
    push_read_data(32'hFF00FF00);
    push_rsp(32'hFF00FF00, 1'b0);
    issue(2'b00, 24'h000000, 32'h0);
    wait_done(2000);
    repeat (3) @(negedge p_clk);
    chk("rdata_hold", rsp_rdata, 32'hFF00FF00);

    // ERASE with WIP stuck: exactly MAX_POLLS frames then timeout
    push_tx(8'h06, 1'b0, 8'h00, 1'b0);
    push_hdr(8'h20, 24'h012345, 1'b1);
    push_poll(8'h01, 1'b0);
    for (int i = 1; i < MAX_POLLS; i++) push_poll(8'h03, 1'b1);
    push_rsp(32'h0, 1'b1);
    issue(2'b10, 24'h012345, 32'h0);
    wait_done(2000);

    // ERASE clearing on the last allowed poll
    push_tx(8'h06, 1'b0, 8'h00, 1'b0);
    push_hdr(8'h20, 24'hABCDEF, 1'b1);
    push_poll(8'h01, 1'b0);
    for (int i = 2; i < MAX_POLLS; i++) push_poll(8'h01, 1'b1);
    push_poll(8'hFE, 1'b1);
    push_rsp(32'h0, 1'b0);
    issue(2'b10, 24'hABCDEF, 32'h0);
    wait_done(2000);

    // READ with the engine stalling on the second address byte
    stall_at = 2;
    push_hdr(8'h03, 24'hA5C3E1, 1'b0);
    push_read_data(32'h12345678);
    push_rsp(32'h12345678, 1'b0);
    issue(2'b00, 24'hA5C3E1, 32'h0);
    wait_done(2000);
    stall_at = -1;

    // Illegal op: immediate error response, no SPI traffic
    push_rsp(32'h0, 1'b1);
    issue(2'b11, 24'h000010, 32'h0);
    chk("illegal_rsp_valid", 32'(rsp_valid), 1);
    chk("illegal_rsp_err", 32'(rsp_err), 1);
    wait_done(2000);

    // Reset during the DATA phase of a READ
    push_hdr(8'h03, 24'h000100, 1'b0);
    push_read_data(32'hCAFEF00D);
    issue(2'b00, 24'h000100, 32'h0);
    n = 0;
    while (tx_count < 6 && n < 500) begin
      @(posedge p_clk);
      #2;
      n++;
    end
    chk("reached_data", 32'(tx_count), 6);
    p_reset = 1'b1;
    exp_q.delete();
    miso_q.delete();
    rsp_q.delete();
    @(negedge p_clk);
    @(posedge p_clk);
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tx_valid", 32'(spi_tx_valid), 0);
    chk("midrst_rdata", rsp_rdata, 0);
    p_reset = 1'b0;

    push_hdr(8'h03, 24'h000004, 1'b0);
    push_read_data(32'hDEADBEEF);
    push_rsp(32'hDEADBEEF, 1'b0);
    issue(2'b00, 24'h000004, 32'h0);
    wait_done(2000);

    repeat (2) @(negedge p_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
